interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//   Arbitrates RESET, NMI, IRQ and BRK requests for the 8227 core and sequences the shared
//   7-cycle interrupt-entry microsequence (2 dummy, push PCH/PCL/P, fetch vector lo/hi).
//   Sits in control_logic beside the decoder; drives stack/vector controls into the datapath.
//   Owns the reset-running flag: set on reset acceptance, cleared when the reset sequence completes.
// PARAMETERS
//   VEC_NMI    16'hFFFA  NMI vector low-byte address
//   VEC_RESET  16'hFFFC  RESET vector low-byte address
//   VEC_IRQ    16'hFFFE  IRQ/BRK vector low-byte address
// PORTS
//   clk             in   1   system clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   enable_ffs      in   1   global stall; 0 = all state holds, strobes forced 0
//   reset_req       in   1   external reset request, level
//   nmi_n           in   1   NMI line, active-low, falling-edge triggered
//   irq_n           in   1   IRQ line, active-low, level
//   i_flag          in   1   processor status I flag
//   instr_boundary  in   1   high in the cycle the next opcode would be fetched
//   brk_decoded     in   1   BRK opcode decoded at instr_boundary
//   busy            out  1   sequence in progress; decoder must not fetch
//   step            out  3   current step 0..6 (0 when idle)
//   stack_push      out  1   push this cycle (decrement SP)
//   stack_wr_en     out  1   memory write on push (0 for RESET pushes)
//   push_sel        out  2   0=PCH 1=PCL 2=P
//   push_b_flag     out  1   B bit value in pushed P (1 only for BRK)
//   vector_addr     out  16  vector byte address, valid when vector_rd=1
//   vector_rd       out  1   vector fetch this cycle
//   set_i_flag      out  1   1-cycle pulse: set I
//   reset_running   out  1   reset sequence active
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, NMI edge latch 0, nmi_n history 1.
//   NMI latch: set on sampled 1->0 of nmi_n; cleared at the step-5 edge of a sequence that vectors to NMI.
//   Acceptance (IDLE, enable_ffs=1): reset_req any cycle; others only at instr_boundary.
//   Priority: RESET > NMI latch > BRK > IRQ (irq_n=0 and i_flag=0). Type latched on acceptance.
//   FSM: IDLE -> S0 -> S1 -> PCH -> PCL -> P -> VLO -> VHI -> IDLE; step = 0..6, one step per enabled clock.
//   busy=1 from the cycle after acceptance through VHI inclusive; 7 cycles total.
//   PCH/PCL/P: stack_push=1, push_sel 0/1/2, stack_wr_en=0 if type RESET else 1.
//   VLO: vector_rd=1, vector_addr=base, set_i_flag=1. VHI: vector_rd=1, vector_addr=base+1.
//   Hijack: if NMI latch is set before the P step ends during IRQ/BRK, base becomes VEC_NMI; push_b_flag keeps BRK value.
//   RESET mid-sequence: reset_req restarts at S0 with type RESET on next edge; pending NMI latch kept.
//   reset_running: 1 from acceptance edge of RESET; 0 on edge leaving VHI; reset_req held high re-arms each cycle (stays in S0).
//   enable_ffs=0: state, step, latches hold; stack_push/vector_rd/set_i_flag forced 0.
//   IRQ released mid-sequence: sequence completes unchanged.
// CONFIGURATION
//   INT_INPUT_SYNC_EN defined: nmi_n, irq_n, reset_req pass through 2-flop synchronisers (reset to 1,1,0);
//     acceptance latency +2 cycles.
//   Undefined: inputs sampled directly; caller guarantees synchronous inputs.
// STRUCTURE
//   Package interrupt_pkg: int_type_t enum {INT_NONE, INT_RESET, INT_NMI, INT_BRK, INT_IRQ},
//     seq_state_t enum, PUSH_PCH/PUSH_PCL/PUSH_P localparams.
//   Sub-module int_edge_latch: nmi falling-edge detect + latch with clear, honouring enable_ffs.
// TESTING
//   1 rst pulse, then reset_req 1 cycle -> reset_running=1, 3 pushes with stack_wr_en=0, vector_addr FFFC,FFFD, busy 7 cycles.
//   2 irq_n=0, i_flag=0, instr_boundary -> pushes sel 0,1,2 wr_en=1, push_b_flag=0, vector FFFE/FFFF, set_i_flag at step 5.
//   3 irq_n=0, i_flag=1, boundary -> no sequence, busy stays 0; brk_decoded then -> vector FFFE, push_b_flag=1.
//   4 BRK accepted, nmi_n falls at step 2 -> vector FFFA/FFFB, push_b_flag=1, NMI latch cleared after.
//   5 NMI and IRQ pending same boundary -> NMI served first, IRQ at next boundary; reset_req at step 3 -> restart, vector FFFC.
//   6 enable_ffs=0 for 4 cycles at step 2 -> step stays 2, strobes 0; resumes, total 11 cycles busy.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared types for the 8227 interrupt sequencer: request kinds, sequence states and push selectors.
package interrupt_pkg;

    typedef enum logic [2:0] {
        INT_NONE,
        INT_RESET,
        INT_NMI,
        INT_BRK,
        INT_IRQ
    } int_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_PCH,
        ST_PCL,
        ST_P,
        ST_VLO,
        ST_VHI
    } seq_state_t;

    localparam logic [1:0] PUSH_PCH = 2'd0;
    localparam logic [1:0] PUSH_PCL = 2'd1;
    localparam logic [1:0] PUSH_P   = 2'd2;

    // Idle and the first dummy cycle both report step 0.
    function automatic logic [2:0] step_of(seq_state_t s);
        case (s)
            ST_S1:   step_of = 3'd1;
            ST_PCH:  step_of = 3'd2;
            ST_PCL:  step_of = 3'd3;
            ST_P:    step_of = 3'd4;
            ST_VLO:  step_of = 3'd5;
            ST_VHI:  step_of = 3'd6;
            default: step_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_edge_latch.sv
// NMI falling-edge detector with a sticky pending latch; frozen while the core is stalled.
module int_edge_latch (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic nmi_n_i,
    input  logic clr_i,
    output logic edge_o,
    output logic pending_o
);

    logic prev_q;
    logic latch_q;
    logic latch_d;

    assign edge_o    = enable_i & prev_q & ~nmi_n_i;
    assign pending_o = latch_q;

    // A fresh edge wins over a clear so an NMI arriving during vector fetch is not lost.
    always_comb begin
        latch_d = latch_q;
        if (edge_o) begin
            latch_d = 1'b1;
        end else if (clr_i) begin
            latch_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= 1'b1;
            latch_q <= 1'b0;
        end else if (enable_i) begin
            prev_q  <= nmi_n_i;
            latch_q <= latch_d;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 8227 interrupt arbiter and 7-cycle entry sequencer (dummy x2, push PCH/PCL/P, vector lo/hi).
// Define INT_INPUT_SYNC_EN to pass nmi_n, irq_n and reset_req through 2-flop synchronisers.
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter logic [15:0] VEC_NMI   = 16'hFFFA,
    parameter logic [15:0] VEC_RESET = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ   = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_ffs,
    input  logic        reset_req,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        instr_boundary,
    input  logic        brk_decoded,
    output logic        busy,
    output logic [2:0]  step,
    output logic        stack_push,
    output logic        stack_wr_en,
    output logic [1:0]  push_sel,
    output logic        push_b_flag,
    output logic [15:0] vector_addr,
    output logic        vector_rd,
    output logic        set_i_flag,
    output logic        reset_running
);

    logic nmi_n_s;
    logic irq_n_s;
    logic reset_req_s;

`ifdef INT_INPUT_SYNC_EN
    logic [1:0] nmi_sync_q;
    logic [1:0] irq_sync_q;
    logic [1:0] rreq_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_sync_q  <= 2'b11;
            irq_sync_q  <= 2'b11;
            rreq_sync_q <= 2'b00;
        end else begin
            nmi_sync_q  <= {nmi_sync_q[0], nmi_n};
            irq_sync_q  <= {irq_sync_q[0], irq_n};
            rreq_sync_q <= {rreq_sync_q[0], reset_req};
        end
    end

    assign nmi_n_s     = nmi_sync_q[1];
    assign irq_n_s     = irq_sync_q[1];
    assign reset_req_s = rreq_sync_q[1];
`else
    assign nmi_n_s     = nmi_n;
    assign irq_n_s     = irq_n;
    assign reset_req_s = reset_req;
`endif

    seq_state_t  state_q, state_d;
    int_type_t   type_q, type_d;
    logic        busy_q, push_q, wr_q, b_q, vrd_q, seti_q, rr_q;
    logic [2:0]  step_q;
    logic [1:0]  sel_q;
    logic [15:0] vaddr_q;
    logic [15:0] vec_base_d;
    logic        nmi_edge, nmi_pend, nmi_clr;

    // The latch is released only once the NMI vector has actually been issued.
    assign nmi_clr = enable_ffs && (state_q == ST_VLO) && (vaddr_q == VEC_NMI);

    int_edge_latch u_nmi_latch (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable_i  (enable_ffs),
        .nmi_n_i   (nmi_n_s),
        .clr_i     (nmi_clr),
        .edge_o    (nmi_edge),
        .pending_o (nmi_pend)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        if (reset_req_s) begin
            state_d = ST_S0;
            type_d  = INT_RESET;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_boundary) begin
                        if (nmi_pend) begin
                            state_d = ST_S0;
                            type_d  = INT_NMI;
                        end else if (brk_decoded) begin
                            state_d = ST_S0;
                            type_d  = INT_BRK;
                        end else if (!irq_n_s && !i_flag) begin
                            state_d = ST_S0;
                            type_d  = INT_IRQ;
                        end
                    end
                end
                ST_S0:   state_d = ST_S1;
                ST_S1:   state_d = ST_PCH;
                ST_PCH:  state_d = ST_PCL;
                ST_PCL:  state_d = ST_P;
                ST_P:    state_d = ST_VLO;
                ST_VLO:  state_d = ST_VHI;
                ST_VHI: begin
                    state_d = ST_IDLE;
                    type_d  = INT_NONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // An NMI seen up to the end of the P push hijacks an IRQ/BRK onto the NMI vector.
    always_comb begin
        if (type_d == INT_RESET) begin
            vec_base_d = VEC_RESET;
        end else if (type_d == INT_NMI || nmi_pend || nmi_edge) begin
            vec_base_d = VEC_NMI;
        end else begin
            vec_base_d = VEC_IRQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= INT_NONE;
            busy_q  <= 1'b0;
            step_q  <= 3'd0;
            push_q  <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= PUSH_PCH;
            b_q     <= 1'b0;
            vrd_q   <= 1'b0;
            vaddr_q <= 16'h0000;
            seti_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else if (enable_ffs) begin
            state_q <= state_d;
            type_q  <= type_d;
            busy_q  <= (state_d != ST_IDLE);
            step_q  <= step_of(state_d);
            push_q  <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= PUSH_PCH;
            b_q     <= 1'b0;
            vrd_q   <= 1'b0;
            vaddr_q <= 16'h0000;
            seti_q  <= 1'b0;
            case (state_d)
                ST_PCH: begin
                    push_q <= 1'b1;
                    wr_q   <= (type_d != INT_RESET);
                    sel_q  <= PUSH_PCH;
                end
                ST_PCL: begin
                    push_q <= 1'b1;
                    wr_q   <= (type_d != INT_RESET);
                    sel_q  <= PUSH_PCL;
                end
                ST_P: begin
                    push_q <= 1'b1;
                    wr_q   <= (type_d != INT_RESET);
                    sel_q  <= PUSH_P;
                    b_q    <= (type_d == INT_BRK);
                end
                ST_VLO: begin
                    vrd_q   <= 1'b1;
                    vaddr_q <= vec_base_d;
                    seti_q  <= 1'b1;
                end
                ST_VHI: begin
                    vrd_q   <= 1'b1;
                    vaddr_q <= vaddr_q + 16'd1;
                end
                default: ;
            endcase
            if (state_d == ST_S0 && type_d == INT_RESET) begin
                rr_q <= 1'b1;
            end else if (state_q == ST_VHI) begin
                rr_q <= 1'b0;
            end
        end
    end

    assign busy          = busy_q;
    assign step          = step_q;
    assign stack_push    = push_q & enable_ffs;
    assign stack_wr_en   = wr_q;
    assign push_sel      = sel_q;
    assign push_b_flag   = b_q;
    assign vector_addr   = vaddr_q;
    assign vector_rd     = vrd_q & enable_ffs;
    assign set_i_flag    = seti_q & enable_ffs;
    assign reset_running = rr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus queues expected per-cycle records, a monitor checks them.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_ffs = 1'b1;
    logic        reset_req = 1'b0;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        i_flag = 1'b1;
    logic        instr_boundary = 1'b0;
    logic        brk_decoded = 1'b0;
    logic        busy;
    logic [2:0]  step;
    logic        stack_push;
    logic        stack_wr_en;
    logic [1:0]  push_sel;
    logic        push_b_flag;
    logic [15:0] vector_addr;
    logic        vector_rd;
    logic        set_i_flag;
    logic        reset_running;

    interrupt_sequencer u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable_ffs     (enable_ffs),
        .reset_req      (reset_req),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .i_flag         (i_flag),
        .instr_boundary (instr_boundary),
        .brk_decoded    (brk_decoded),
        .busy           (busy),
        .step           (step),
        .stack_push     (stack_push),
        .stack_wr_en    (stack_wr_en),
        .push_sel       (push_sel),
        .push_b_flag    (push_b_flag),
        .vector_addr    (vector_addr),
        .vector_rd      (vector_rd),
        .set_i_flag     (set_i_flag),
        .reset_running  (reset_running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  step;
        logic        push;
        logic        wr;
        logic [1:0]  sel;
        logic        b;
        logic        vrd;
        logic [15:0] addr;
        logic        seti;
        logic        rr;
    } rec_t;

    rec_t  exp_q[$];
    rec_t  mon_act;
    rec_t  mon_exp;
    int    passed = 0;
    int    total = 0;
    int    rec_idx = 0;
    string tag = "init";

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s actual=%h expected=%h", name, act, expv);
    endtask

    // Queue the per-cycle outputs of steps 0..last_s; stall_n stalled copies of step 2 precede it.
    task automatic push_seq(input logic wr, input logic b, input logic [15:0] base,
                            input logic rr, input int last_s, input int stall_n);
        rec_t r;
        rec_t st;
        for (int s = 0; s <= last_s; s++) begin
            r = '0;
            r.step = 3'(s);
            r.rr = rr;
            if (s >= 2 && s <= 4) begin
                r.push = 1'b1;
                r.wr = wr;
                r.sel = 2'(s - 2);
            end
            if (s == 4) r.b = b;
            if (s == 5) begin
                r.vrd = 1'b1;
                r.addr = base;
                r.seti = 1'b1;
            end
            if (s == 6) begin
                r.vrd = 1'b1;
                r.addr = base + 16'd1;
            end
            if (s == 2) begin
                for (int k = 0; k < stall_n; k++) begin
                    st = r;
                    st.push = 1'b0;
                    exp_q.push_back(st);
                end
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        check({"idle_", tag}, 32'({exp_q.size() == 0, busy, reset_running, stack_push, vector_rd, set_i_flag}),
              32'b100000);
    endtask

    always @(negedge clk) begin
        if (!rst && busy) begin
            mon_act = {step, stack_push, stack_wr_en, push_sel, push_b_flag, vector_rd,
                       vector_addr, set_i_flag, reset_running};
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_busy_%s actual=%h expected=no_sequence", tag, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act === mon_exp) passed++;
                else $display("FAIL rec_%s[%0d] actual=%h expected=%h", tag, rec_idx, mon_act, mon_exp);
            end
            rec_idx++;
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_outputs", 32'({busy, step, stack_push, stack_wr_en, push_sel, push_b_flag,
                                    vector_addr, vector_rd, set_i_flag, reset_running}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_after_reset", 32'({busy, reset_running}), 32'd0);

        tag = "reset"; rec_idx = 0;
        reset_req = 1'b1;
        push_seq(1'b0, 1'b0, 16'hFFFC, 1'b1, 6, 0);
        tick();
        reset_req = 1'b0;
        check("reset_running_set", 32'(reset_running), 32'd1);
        wait_idle();

        tag = "irq"; rec_idx = 0;
        irq_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
        push_seq(1'b1, 1'b0, 16'hFFFE, 1'b0, 6, 0);
        tick();
        instr_boundary = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
        wait_idle();

        tag = "masked"; rec_idx = 0;
        irq_n = 1'b0; i_flag = 1'b1; instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tick();
        tick();
        check("masked_irq_no_busy", 32'(busy), 32'd0);
        tag = "brk"; rec_idx = 0;
        brk_decoded = 1'b1; instr_boundary = 1'b1;
        push_seq(1'b1, 1'b1, 16'hFFFE, 1'b0, 6, 0);
        tick();
        brk_decoded = 1'b0; instr_boundary = 1'b0; irq_n = 1'b1;
        wait_idle();

        tag = "hijack"; rec_idx = 0;
        brk_decoded = 1'b1; instr_boundary = 1'b1;
        push_seq(1'b1, 1'b1, 16'hFFFA, 1'b0, 6, 0);
        tick();
        brk_decoded = 1'b0; instr_boundary = 1'b0;
        tick();
        tick();
        nmi_n = 1'b0;
        wait_idle();
        nmi_n = 1'b1;
        tick();
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tick();
        check("nmi_latch_cleared", 32'(busy), 32'd0);

        tag = "nmi_first"; rec_idx = 0;
        nmi_n = 1'b0;
        tick();
        irq_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
        push_seq(1'b1, 1'b0, 16'hFFFA, 1'b0, 6, 0);
        tick();
        instr_boundary = 1'b0;
        wait_idle();
        tag = "irq_then_reset"; rec_idx = 0;
        instr_boundary = 1'b1;
        push_seq(1'b1, 1'b0, 16'hFFFE, 1'b0, 3, 0);
        push_seq(1'b0, 1'b0, 16'hFFFC, 1'b1, 6, 0);
        tick();
        instr_boundary = 1'b0;
        tick();
        tick();
        tick();
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0; irq_n = 1'b1; i_flag = 1'b1; nmi_n = 1'b1;
        check("restart_reset_running", 32'({reset_running, step}), 32'({1'b1, 3'd0}));
        wait_idle();

        tag = "stall"; rec_idx = 0;
        irq_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
        push_seq(1'b1, 1'b0, 16'hFFFE, 1'b0, 6, 4);
        tick();
        instr_boundary = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
        tick();
        tick();
        enable_ffs = 1'b0;
        repeat (4) tick();
        enable_ffs = 1'b1;
        wait_idle();

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
